// File: rtl/pwm_deadtime_ip.sv
// Dead-time insertion stage: turns a single-ended PWM into a complementary
// high-side/low-side gate-drive pair, with fault shutdown and Avalon-MM registers.
module pwm_deadtime_ip #(
    parameter int unsigned DT_W = 16
) (
    input  logic        csi_clk,
    input  logic        csi_reset_n,
    input  logic        avs_chipselect,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        coe_pwm_in,
    input  logic        coe_fault_n,
    output logic        coe_hi_out,
    output logic        coe_lo_out
);

    typedef enum logic [2:0] {
        IDLE,
        DT_TO_HI,
        HI_ON,
        DT_TO_LO,
        LO_ON,
        FAULT
    } state_t;

    localparam logic [DT_W-1:0] DT_ONE = DT_W'(1);

    state_t          state_q, state_d;
    logic [DT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      pwm_sync_q;
    logic [1:0]      fault_sync_q;

    logic            en_q, hi_inv_q, lo_inv_q;
    logic [DT_W-1:0] dt_rise_q, dt_fall_q;
    logic            fault_q, fault_d;
    logic            short_q, short_d;
    logic            hi_out_q, lo_out_q;
    logic [31:0]     rdata_q, rdata_d;

    logic            pwm_s, pwm_rise, pwm_fall, fault_s;
    logic            wr_en, rd_en, short_set;
    logic [DT_W-1:0] rise_ld, fall_ld;
    logic            unused_wdata;

    assign pwm_s    = pwm_sync_q[1];
    assign pwm_rise = pwm_sync_q[1] & ~pwm_sync_q[2];
    assign pwm_fall = ~pwm_sync_q[1] & pwm_sync_q[2];
    assign fault_s  = fault_sync_q[1];

    assign wr_en = avs_chipselect & avs_write;
    assign rd_en = avs_chipselect & avs_read;

    // A programmed dead time of zero still yields a one-cycle gap.
    assign rise_ld = (dt_rise_q == '0) ? DT_ONE : dt_rise_q;
    assign fall_ld = (dt_fall_q == '0) ? DT_ONE : dt_fall_q;

    assign unused_wdata = ^avs_writedata;

    // Priority: fault, then enable, then edge/counter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        short_set = 1'b0;
        if (!fault_s) begin
            state_d = FAULT;
        end else if (state_q == FAULT) begin
            if (!fault_q) state_d = IDLE;
        end else if (!en_q) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pwm_s) begin
                        state_d = DT_TO_HI;
                        cnt_d   = rise_ld;
                    end else begin
                        state_d = DT_TO_LO;
                        cnt_d   = fall_ld;
                    end
                end
                DT_TO_HI: begin
                    if (pwm_fall) begin
                        short_set = 1'b1;
                        state_d   = DT_TO_LO;
                        cnt_d     = fall_ld;
                    end else if (cnt_q == DT_ONE) begin
                        state_d = HI_ON;
                    end else begin
                        cnt_d = cnt_q - DT_ONE;
                    end
                end
                HI_ON: begin
                    if (pwm_fall) begin
                        state_d = DT_TO_LO;
                        cnt_d   = fall_ld;
                    end
                end
                DT_TO_LO: begin
                    if (pwm_rise) begin
                        short_set = 1'b1;
                        state_d   = DT_TO_HI;
                        cnt_d     = rise_ld;
                    end else if (cnt_q == DT_ONE) begin
                        state_d = LO_ON;
                    end else begin
                        cnt_d = cnt_q - DT_ONE;
                    end
                end
                LO_ON: begin
                    if (pwm_rise) begin
                        state_d = DT_TO_HI;
                        cnt_d   = rise_ld;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Set events win over a simultaneous write-1-to-clear.
    always_comb begin
        fault_d = ~fault_s | (fault_q & ~(wr_en && avs_address == 2'd3 && avs_writedata[0]));
        short_d = short_set | (short_q & ~(wr_en && avs_address == 2'd3 && avs_writedata[3]));
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            case (avs_address)
                2'd0:    rdata_d = {29'd0, lo_inv_q, hi_inv_q, en_q};
                2'd1:    rdata_d = 32'(dt_rise_q);
                2'd2:    rdata_d = 32'(dt_fall_q);
                default: rdata_d = {28'd0, short_q, state_q == LO_ON, state_q == HI_ON, fault_q};
            endcase
        end
    end

    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            pwm_sync_q   <= '0;
            fault_sync_q <= '1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            en_q         <= 1'b0;
            hi_inv_q     <= 1'b0;
            lo_inv_q     <= 1'b0;
            dt_rise_q    <= '0;
            dt_fall_q    <= '0;
            fault_q      <= 1'b0;
            short_q      <= 1'b0;
            hi_out_q     <= 1'b0;
            lo_out_q     <= 1'b0;
            rdata_q      <= '0;
        end else begin
            pwm_sync_q   <= {pwm_sync_q[1:0], coe_pwm_in};
            fault_sync_q <= {fault_sync_q[0], coe_fault_n};
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fault_q      <= fault_d;
            short_q      <= short_d;
            // Outputs follow the next state so they change on the same edge as the FSM.
            hi_out_q     <= (state_d == HI_ON) ^ hi_inv_q;
            lo_out_q     <= (state_d == LO_ON) ^ lo_inv_q;
            rdata_q      <= rdata_d;
            if (wr_en) begin
                case (avs_address)
                    2'd0: begin
                        en_q     <= avs_writedata[0];
                        hi_inv_q <= avs_writedata[1];
                        lo_inv_q <= avs_writedata[2];
                    end
                    2'd1:    dt_rise_q <= avs_writedata[DT_W-1:0];
                    2'd2:    dt_fall_q <= avs_writedata[DT_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    assign coe_hi_out   = hi_out_q;
    assign coe_lo_out   = lo_out_q;
    assign avs_readdata = rdata_q;

endmodule
